// File: rtl/ym2149_regfile_x2.sv
// Dual YM2149/AY-3-8910 shadow register file with an oversampled AY bus-protocol engine.
// Bus handshake: an access is a level on {bdir,bc1}; once it has been stable for FILTER_LEN synchronised samples its action fires once on state entry.
module ym2149_regfile_x2 #(
  parameter int FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bdir,
  input  logic       bc1,
  input  logic [1:0] a8,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       rd_chip,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [1:0] env_restart,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_LATCH = 2'b11
  } state_t;

  function automatic logic [7:0] mask_of(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: mask_of = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: mask_of = 8'h1F;
      default:                 mask_of = 8'hFF;
    endcase
  endfunction

  logic [11:0] sync1_q, sync2_q;
  logic [1:0]  hist_q [3];
  state_t      state_q, state_d;
  logic [1:0]  env_q, env_d;
  logic        chip_q, chip_ok_q;
  logic [3:0]  addr_q [2];
  logic [1:0]  av_q;
  logic [7:0]  regs_q [2][16];

  logic [1:0]  mode_s;
  logic [1:0]  a8_s;
  logic [7:0]  d_s;
  logic        agree;
  logic        entry;
  logic        sel_ok;
  logic        sel_chip;
  logic        lat_en;
  logic        wr_en;

  assign mode_s   = sync2_q[11:10];
  assign a8_s     = sync2_q[9:8];
  assign d_s      = sync2_q[7:0];
  assign sel_ok   = a8_s[1] ^ a8_s[0];
  assign sel_chip = a8_s[1];

  // The current synchronised sample plus the previous FILTER_LEN-1 must all agree.
  always_comb begin
    agree = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < FILTER_LEN - 1 && hist_q[i] != mode_s) agree = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_en  = 1'b0;
    wr_en   = 1'b0;
    env_d   = 2'b00;
    if (agree) state_d = state_t'(mode_s);
    entry = (state_d != state_q);
    if (entry && sel_ok) begin
      case (state_d)
        ST_LATCH: lat_en = 1'b1;
        ST_WRITE: begin
          if (av_q[sel_chip]) begin
            wr_en = 1'b1;
            if (addr_q[sel_chip] == 4'd13) env_d[sel_chip] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      env_q   <= 2'b00;
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 3; i++) hist_q[i] <= 2'b00;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      sync1_q <= {bdir, bc1, a8, d_in};
      sync2_q <= sync1_q;
      hist_q[0] <= mode_s;
      for (int i = 1; i < 3; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chip_q    <= 1'b0;
      chip_ok_q <= 1'b0;
      av_q      <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        addr_q[c] <= 4'd0;
        for (int r = 0; r < 16; r++) regs_q[c][r] <= 8'h00;
      end
    end else begin
      if (entry) begin
        chip_q    <= sel_chip;
        chip_ok_q <= sel_ok;
      end
      // A non-zero upper nibble (e.g. the 0xFE/0xFF chip-select writes) drops the address.
      if (lat_en) begin
        if (d_s[7:4] == 4'h0) begin
          addr_q[sel_chip] <= d_s[3:0];
          av_q[sel_chip]   <= 1'b1;
        end else begin
          av_q[sel_chip] <= 1'b0;
        end
      end
      if (wr_en) regs_q[sel_chip][addr_q[sel_chip]] <= d_s & mask_of(addr_q[sel_chip]);
    end
  end

  assign d_oe        = (state_q == ST_READ) && chip_ok_q && av_q[chip_q];
  assign d_out       = d_oe ? regs_q[chip_q][addr_q[chip_q]] : 8'h00;
  assign rd_data     = regs_q[rd_chip][rd_addr];
  assign env_restart = env_q;
  assign dbg_state   = state_q;

endmodule
